// File: rtl/ws_pkg.sv
// Shared types and constants for the weight-stationary array sequencer.
package ws_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } ws_state_t;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;

    // Activation read (1 cycle) plus one hop per PE row before column 0 emits.
    function automatic int out_lat(input int rows);
        return rows + 1;
    endfunction

endpackage

// File: rtl/ws_valid_skew.sv
// Per-column output-valid skew: tap c is the input delayed by c+1 cycles,
// matching the one-cycle-per-column psum skew across the array.
module ws_valid_skew #(
    parameter int COLS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_vld,
    output logic [COLS-1:0] o_valid
);

    logic [COLS-1:0] r_sr;

    // Shift the column-0 valid across the columns one tap per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_vld;
            for (int c = 1; c < COLS; c++) begin
                r_sr[c] <= r_sr[c-1];
            end
        end
    end

    assign o_valid = r_sr;

endmodule

// File: rtl/ws_array_ctrl.sv
// Sequencer for a ROWSxCOLS weight-stationary PE array:
// clear -> weight load -> activation stream -> psum drain -> done.
// Optional build macro WS_CTRL_WEIGHT_REUSE_EN: a job started with keep_w=1
// skips the weight load (PE clear leaves the weight registers intact).
module ws_array_ctrl
    import ws_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int M_MAX = 255,
    parameter int M_W   = $clog2(M_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [M_W-1:0]          i_cfg_m,
    input  logic                    i_keep_w,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_arr_clear,
    output logic                    o_weight_load,
    output logic                    o_w_rd_en,
    output logic [$clog2(ROWS)-1:0] o_w_rd_row,
    output logic                    o_a_rd_en,
    output logic [M_W-1:0]          o_a_rd_idx,
    output logic [COLS-1:0]         o_out_valid
);

    localparam int OUT_LAT   = out_lat(ROWS);
    localparam int DRAIN_CYC = OUT_LAT + COLS - 1;
    localparam int CNT_MAX0  = (ROWS > M_MAX) ? ROWS : M_MAX;
    localparam int CNT_MAX   = (CNT_MAX0 > DRAIN_CYC) ? CNT_MAX0 : DRAIN_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int RW        = $clog2(ROWS);

    ws_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [M_W-1:0]   r_m;
    logic [ROWS-1:0]  r_vld_pipe;
    logic             w_skip_load;

`ifdef WS_CTRL_WEIGHT_REUSE_EN
    logic r_keep;

    // Remember whether this job reuses the weights already in the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            r_keep <= 1'b0;
        else if (r_state == S_IDLE && i_start) r_keep <= i_keep_w;
    end

    assign w_skip_load = r_keep;
`else
    logic w_unused_keep;
    assign w_unused_keep = i_keep_w;
    assign w_skip_load   = 1'b0;
`endif

    // State, phase counter and job length register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_m     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == S_IDLE && i_start) r_m <= i_cfg_m;
        end
    end

    // Next state, counter and all strobes decoded from the current phase.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_arr_clear   = 1'b0;
        o_weight_load = 1'b0;
        o_w_rd_en     = 1'b0;
        o_w_rd_row    = '0;
        o_a_rd_en     = 1'b0;
        o_a_rd_idx    = '0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (i_start) w_state_nxt = (i_cfg_m == '0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: begin
                o_busy      = 1'b1;
                o_arr_clear = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = w_skip_load ? S_STREAM : S_LOAD_W;
            end
            S_LOAD_W: begin
                // Reads lead the load strobe by one cycle (buffer latency);
                // the farthest row is read first so it shifts down first.
                o_busy = 1'b1;
                if (r_cnt < CNT_W'(ROWS)) begin
                    o_w_rd_en  = 1'b1;
                    o_w_rd_row = RW'(ROWS - 1) - r_cnt[RW-1:0];
                end
                if (r_cnt != '0) o_weight_load = 1'b1;
                if (r_cnt == CNT_W'(ROWS)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STREAM;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STREAM: begin
                o_busy     = 1'b1;
                o_a_rd_en  = 1'b1;
                o_a_rd_idx = r_cnt[M_W-1:0];
                if (r_cnt == CNT_W'(r_m) - CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                // Long enough for the last vector to leave the last column.
                o_busy = 1'b1;
                if (r_cnt == CNT_W'(DRAIN_CYC - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Delay the activation read strobe down the psum depth to column 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= o_a_rd_en;
            for (int i = 1; i < ROWS; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
        end
    end

    ws_valid_skew #(.COLS(COLS)) u_skew (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld   (r_vld_pipe[ROWS-1]),
        .o_valid (o_out_valid)
    );

endmodule

// File: tb/tb_ws_array_ctrl.sv
// Randomized bench for ws_array_ctrl against a closed-form per-cycle job model.
module tb_ws_array_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int M_MAX = 255;
    localparam int M_W   = $clog2(M_MAX + 1);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    i_start = 1'b0;
    logic [M_W-1:0]          i_cfg_m = '0;
    logic                    i_keep_w = 1'b0;
    logic                    o_busy, o_done, o_arr_clear, o_weight_load;
    logic                    o_w_rd_en, o_a_rd_en;
    logic [$clog2(ROWS)-1:0] o_w_rd_row;
    logic [M_W-1:0]          o_a_rd_idx;
    logic [COLS-1:0]         o_out_valid;

    int n_chk = 0;
    int n_err = 0;

    // Model: job_on, its length j_m, weight reuse flag, and d = cycles since acceptance.
    bit job_on = 0;
    int j_m    = 0;
    bit j_keep = 0;
    int d      = 0;

    always #5 clk = ~clk;

    ws_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .M_MAX(M_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_cfg_m      (i_cfg_m),
        .i_keep_w     (i_keep_w),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_arr_clear  (o_arr_clear),
        .o_weight_load(o_weight_load),
        .o_w_rd_en    (o_w_rd_en),
        .o_w_rd_row   (o_w_rd_row),
        .o_a_rd_en    (o_a_rd_en),
        .o_a_rd_idx   (o_a_rd_idx),
        .o_out_valid  (o_out_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h (d=%0d m=%0d t=%0t)", tag, obs, exp, d, j_m, $time);
        end
    endtask

    function automatic int s_first();
        return j_keep ? 2 : ROWS + 3;
    endfunction

    function automatic int job_end();
        return (j_m == 0) ? 1 : s_first() + j_m + ROWS + COLS;
    endfunction

    function automatic bit m_idle();
        return !job_on || d > job_end();
    endfunction

    task automatic check_outputs();
        bit e_busy = 0, e_done = 0, e_clr = 0, e_wl = 0, e_wr = 0, e_ar = 0;
        int e_row = 0, e_idx = 0, s, dd;
        logic [COLS-1:0] e_ov = '0;
        if (job_on) begin
            s  = s_first();
            dd = job_end();
            e_done = (d == dd);
            if (j_m != 0) begin
                e_busy = (d >= 1) && (d < dd);
                e_clr  = (d == 1);
                if (!j_keep) begin
                    e_wr = (d >= 2) && (d <= ROWS + 1);
                    if (e_wr) e_row = ROWS + 1 - d;
                    e_wl = (d >= 3) && (d <= ROWS + 2);
                end
                e_ar = (d >= s) && (d < s + j_m);
                if (e_ar) e_idx = d - s;
                for (int c = 0; c < COLS; c++)
                    e_ov[c] = ((d - s) >= ROWS + 1 + c) && ((d - s) <= ROWS + c + j_m);
            end
        end
        chk("busy",        32'(o_busy),        32'(e_busy));
        chk("done",        32'(o_done),        32'(e_done));
        chk("arr_clear",   32'(o_arr_clear),   32'(e_clr));
        chk("w_rd_en",     32'(o_w_rd_en),     32'(e_wr));
        chk("w_rd_row",    32'(o_w_rd_row),    32'(e_row));
        chk("weight_load", 32'(o_weight_load), 32'(e_wl));
        chk("a_rd_en",     32'(o_a_rd_en),     32'(e_ar));
        chk("a_rd_idx",    32'(o_a_rd_idx),    32'(e_idx));
        chk("out_valid",   32'(o_out_valid),   32'(e_ov));
        chk("excl", 32'(o_a_rd_en & (o_w_rd_en | o_weight_load | o_arr_clear)), 32'd0);
    endtask

    // One clock: check this cycle's outputs, drive this cycle's inputs, advance model.
    task automatic step(input bit st, input int m, input bit kw);
        @(negedge clk);
        check_outputs();
        i_start  = st;
        i_cfg_m  = M_W'(m);
        i_keep_w = kw;
        if (m_idle() && st) begin
            job_on = 1;
            j_m    = m;
`ifdef WS_CTRL_WEIGHT_REUSE_EN
            j_keep = kw;
`else
            j_keep = 0;
`endif
            d = 1;
        end else if (job_on) begin
            d++;
        end
    endtask

    task automatic run_idle();
        for (int k = 0; k < 400 && !m_idle(); k++) step(0, 0, 0);
        step(0, 0, 0);
    endtask

    // Asynchronous reset between clock edges; outputs must clear immediately.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        i_start = 1'b0;
        job_on  = 0;
        #1 check_outputs();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        step(0, 0, 0);
        step(0, 0, 0);
        #1 rst_n = 1'b1;
        step(0, 0, 0);

        // Basic job, m=3: clear/load/stream/drain timing
        step(1, 3, 0);
        run_idle();

        // Empty job: done one cycle later, no strobes
        step(1, 0, 0);
        run_idle();

        // Start pulse during STREAM ignored; start in DONE ignored, accepted next cycle
        step(1, 5, 0);
        for (int k = 0; k < 60; k++)
            step(job_on && (d == s_first() + 1 || (j_m == 5 && d >= job_end())), 2, 0);
        run_idle();

        // Mid-STREAM reset, then a fresh m=2 job
        step(1, 4, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 0);
        async_reset();
        step(1, 2, 0);
        run_idle();

        // keep_w request (skips load only when reuse is built in)
        step(1, 3, 1);
        run_idle();

        // Randomized traffic with occasional resets
        for (int k = 0; k < 4000; k++) begin
            int m;
            m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, M_MAX))
                                            : int'($urandom_range(0, 6));
            step($urandom_range(0, 3) == 0, m, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 499) == 0) async_reset();
        end
        run_idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
